game_turn_ctrl: RTL
===================

GAME_TURN_CTRL -- requirements
Module: game_turn_ctrl

Interface
REQ-001 SHALL have parameter TURN_CYCLES, default 500000, meaning cycles allowed per turn before the turn is forfeited.
REQ-002 SHALL have parameter EDIT_TIMEOUT, default 16, meaning the cycle limit for the edit engine to return finish.
REQ-003 SHALL have parameter BOARD_CELLS, default 64, meaning the move count at which the game is declared a draw.
REQ-004 SHALL use one clock with an asynchronous, active-high reset; ports as listed below.
REQ-005 clk  in  1  system clock, rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 start  in  1  pulse; begins a new game.
REQ-008 move_req  in  1  pulse; current player drops a chip.
REQ-009 edit_wr  in  1  board RAM write strobe from the edit engine.
REQ-010 edit_finish  in  1  edit engine done pulse.
REQ-011 chk_done  in  1  win-check engine done pulse.
REQ-012 chk_win  in  1  win result, valid with chk_done.
REQ-013 edit_en  out  1  one-cycle pulse that launches the edit engine.
REQ-014 chk_start  out  1  one-cycle pulse that launches the win check.
REQ-015 cur_player  out  2  player to move: 1 or 2, never 0 or 3.
REQ-016 move_cnt  out  7  number of valid chips placed this game.
REQ-017 busy  out  1  high in EDIT and CHECK.
REQ-018 game_over  out  1  high in OVER.
REQ-019 winner  out  2  0 = draw or none, 1 or 2 = winning player.
REQ-020 invalid_move  out  1  one-cycle pulse when the selected column was full.
REQ-021 turn_timeout  out  1  one-cycle pulse when a turn is forfeited.
REQ-022 edit_fault  out  1  sticky flag set by the edit watchdog; cleared by start.

Function
REQ-023 SHALL implement the states IDLE, WAIT_MOVE, EDIT, CHECK and OVER.
REQ-024 IDLE: on start, go to WAIT_MOVE; set cur_player=1, move_cnt=0, winner=0, edit_fault=0; load turn timer=TURN_CYCLES-1.
REQ-025 WAIT_MOVE: on move_req, assert edit_en for exactly the following cycle and go to EDIT; clear wr_seen; load edit watchdog=EDIT_TIMEOUT-1.
REQ-026 WAIT_MOVE: the turn timer SHALL decrement each cycle; at 0 with no move_req, pulse turn_timeout, toggle cur_player, reload the timer, and stay in WAIT_MOVE.
REQ-027 If move_req and timer expiry coincide, move_req SHALL win and no timeout occurs.
REQ-028 EDIT: set wr_seen on any edit_wr; the turn timer SHALL hold.
REQ-029 EDIT: on edit_finish with wr_seen or edit_wr in the same cycle, increment move_cnt, pulse chk_start the next cycle, and go to CHECK.
REQ-030 EDIT: on edit_finish with no write, pulse invalid_move and return to WAIT_MOVE; cur_player and the timer value are unchanged (no reload).
REQ-031 EDIT: if the watchdog reaches 0 without edit_finish, set edit_fault and go to IDLE.
REQ-032 CHECK: on chk_done with chk_win=1, set winner=cur_player and go to OVER.
REQ-033 CHECK: on chk_done with chk_win=0 and move_cnt==BOARD_CELLS, set winner=0 and go to OVER.
REQ-034 CHECK: otherwise toggle cur_player (1<->2), reload the timer, and go to WAIT_MOVE.
REQ-035 OVER: hold winner and move_cnt; start behaves as in IDLE.
REQ-036 start SHALL be ignored in WAIT_MOVE, EDIT and CHECK; move_req SHALL be ignored outside WAIT_MOVE.
REQ-037 move_cnt SHALL saturate at BOARD_CELLS.
REQ-038 Pulses arriving in the wrong state (edit_finish, chk_done) SHALL be ignored.

Reset
REQ-039 rst SHALL force: state=IDLE, cur_player=1, move_cnt=0, winner=0, all pulses 0, busy=0, game_over=0, edit_fault=0, timers=0.
REQ-040 rst asserted mid-EDIT or mid-CHECK SHALL abort immediately with no further edit_en or chk_start.

Structure
REQ-041 The state encoding and the player constants (P1=1, P2=2) SHALL live in a shared package, connect4_pkg.
REQ-042 The turn timer SHALL be one sub-module, turn_timer, with load, enable, and expired signals.

Verification
REQ-043 start, then move_req; edit_wr at +3, edit_finish at +4, chk_done with win=0 -> edit_en 1 cycle after move_req, chk_start once, move_cnt=1, cur_player=2.
REQ-044 move_req; edit_finish with no edit_wr -> invalid_move pulse, cur_player unchanged, state WAIT_MOVE, move_cnt unchanged.
REQ-045 TURN_CYCLES=10, no move -> turn_timeout at cycle 10 after start, cur_player=2; move_req on the expiry cycle -> no timeout.
REQ-046 chk_win=1 while cur_player=2 -> game_over=1, winner=2; a later start -> cur_player=1, move_cnt=0.
REQ-047 BOARD_CELLS=4, four valid moves with no win -> OVER with winner=0, move_cnt=4.
REQ-048 edit_finish withheld for 16 cycles -> edit_fault=1, IDLE; rst pulse during CHECK -> all outputs at reset values.

Source files
------------

// File: rtl/connect4_pkg.sv
// rtl/connect4_pkg.sv - shared state encoding and player constants for the turn controller
package connect4_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_MOVE,
      ST_EDIT,
      ST_CHECK,
      ST_OVER
   } state_t;

   localparam logic [1:0] P1 = 2'd1;
   localparam logic [1:0] P2 = 2'd2;

   function automatic logic [1:0] other_player(input logic [1:0] p);
      return (p == P1) ? P2 : P1;
   endfunction

endpackage

// File: rtl/turn_timer.sv
// rtl/turn_timer.sv - per-turn down-counter; expired while the count sits at zero
module turn_timer #(
   parameter int unsigned CYCLES = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic enable,
   output logic expired
);

   localparam int unsigned W = $clog2(CYCLES + 1);
   localparam logic [W-1:0] RELOAD = W'(CYCLES - 1);

   logic [W-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= RELOAD;
      end else if (enable && (count != '0)) begin
         count <= count - W'(1);
      end
   end

   assign expired = (count == '0);

endmodule

// File: rtl/game_turn_ctrl.sv
// rtl/game_turn_ctrl.sv - connect-four turn sequencer driving the edit and win-check engines
module game_turn_ctrl
   import connect4_pkg::*;
#(
   parameter int unsigned TURN_CYCLES  = 500000,
   parameter int unsigned EDIT_TIMEOUT = 16,
   parameter int unsigned BOARD_CELLS  = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       move_req,
   input  logic       edit_wr,
   input  logic       edit_finish,
   input  logic       chk_done,
   input  logic       chk_win,
   output logic       edit_en,
   output logic       chk_start,
   output logic [1:0] cur_player,
   output logic [6:0] move_cnt,
   output logic       busy,
   output logic       game_over,
   output logic [1:0] winner,
   output logic       invalid_move,
   output logic       turn_timeout,
   output logic       edit_fault
);

   localparam int unsigned WD_W = $clog2(EDIT_TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_LOAD = WD_W'(EDIT_TIMEOUT - 1);
   localparam logic [6:0] FULL = 7'(BOARD_CELLS);

   state_t          state, state_n;
   logic [1:0]      player_n, winner_n;
   logic [6:0]      cnt_n;
   logic            fault_n, wr_seen, wr_seen_n;
   logic [WD_W-1:0] wdog, wdog_n;
   logic            edit_en_n, chk_start_n, invalid_n, timeout_n;
   logic            timer_load, timer_en, timer_expired;

   turn_timer #(.CYCLES(TURN_CYCLES)) u_turn_timer (
      .clk     (clk),
      .rst     (rst),
      .load    (timer_load),
      .enable  (timer_en),
      .expired (timer_expired)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         cur_player   <= P1;
         move_cnt     <= '0;
         winner       <= '0;
         edit_fault   <= 1'b0;
         wr_seen      <= 1'b0;
         wdog         <= '0;
         edit_en      <= 1'b0;
         chk_start    <= 1'b0;
         invalid_move <= 1'b0;
         turn_timeout <= 1'b0;
      end else begin
         state        <= state_n;
         cur_player   <= player_n;
         move_cnt     <= cnt_n;
         winner       <= winner_n;
         edit_fault   <= fault_n;
         wr_seen      <= wr_seen_n;
         wdog         <= wdog_n;
         edit_en      <= edit_en_n;
         chk_start    <= chk_start_n;
         invalid_move <= invalid_n;
         turn_timeout <= timeout_n;
      end
   end

   always_comb begin
      state_n     = state;
      player_n    = cur_player;
      cnt_n       = move_cnt;
      winner_n    = winner;
      fault_n     = edit_fault;
      wr_seen_n   = wr_seen;
      wdog_n      = wdog;
      edit_en_n   = 1'b0;
      chk_start_n = 1'b0;
      invalid_n   = 1'b0;
      timeout_n   = 1'b0;
      timer_load  = 1'b0;
      timer_en    = 1'b0;
      case (state)
         ST_IDLE, ST_OVER: begin
            if (start) begin
               state_n    = ST_WAIT_MOVE;
               player_n   = P1;
               cnt_n      = '0;
               winner_n   = '0;
               fault_n    = 1'b0;
               timer_load = 1'b1;
            end
         end
         ST_WAIT_MOVE: begin
            // A move on the expiry cycle takes priority over forfeiting the turn
            if (move_req) begin
               state_n   = ST_EDIT;
               edit_en_n = 1'b1;
               wr_seen_n = 1'b0;
               wdog_n    = WD_LOAD;
            end else if (timer_expired) begin
               timeout_n  = 1'b1;
               player_n   = other_player(cur_player);
               timer_load = 1'b1;
            end else begin
               timer_en = 1'b1;
            end
         end
         ST_EDIT: begin
            if (edit_wr) wr_seen_n = 1'b1;
            if (edit_finish) begin
               if (wr_seen || edit_wr) begin
                  cnt_n       = (move_cnt < FULL) ? move_cnt + 7'd1 : move_cnt;
                  chk_start_n = 1'b1;
                  state_n     = ST_CHECK;
               end else begin
                  invalid_n = 1'b1;
                  state_n   = ST_WAIT_MOVE;
               end
            end else if (wdog == '0) begin
               fault_n = 1'b1;
               state_n = ST_IDLE;
            end else begin
               wdog_n = wdog - WD_W'(1);
            end
         end
         ST_CHECK: begin
            if (chk_done) begin
               if (chk_win) begin
                  winner_n = cur_player;
                  state_n  = ST_OVER;
               end else if (move_cnt == FULL) begin
                  winner_n = '0;
                  state_n  = ST_OVER;
               end else begin
                  player_n   = other_player(cur_player);
                  timer_load = 1'b1;
                  state_n    = ST_WAIT_MOVE;
               end
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   assign busy      = (state == ST_EDIT) || (state == ST_CHECK);
   assign game_over = (state == ST_OVER);

endmodule
